// File: rtl/write_engine_pkg.sv
// Shared types and constants for the write engine.
package write_engine_pkg;

    localparam int CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/write_engine_counter.sv
// Free-running up-counter with synchronous active-low clear and count enable.
module write_engine_counter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    output logic [WIDTH-1:0] VALUE
);

    // Count register: clear has priority over increment.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            VALUE <= {WIDTH{1'b0}};
        end else if (EN) begin
            VALUE <= VALUE + WIDTH'(1);
        end
    end

endmodule

// File: rtl/write_engine.sv
// Write engine: latches a (start address, length) command, turns each accepted
// upstream beat into one peripheral write, and counts requests and acks separately.
module write_engine
    import write_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  WRITE_START,
    input  logic [ADDR_WIDTH-1:0] WADDR_START,
    input  logic [CNT_WIDTH-1:0]  WRITE_LENGTH,
    output logic                  BUSY,
    output logic                  WREQ_COUNT_DONE,
    output logic                  WACK_COUNT_DONE,
    output logic                  WACK_OVERFLOW,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  IN_READY,
    output logic                  WREQ,
    output logic [ADDR_WIDTH-1:0] WADDR,
    output logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WACK
);

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_WIDTH-1:0]  r_length;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wreq;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_overflow;

    logic [CNT_WIDTH-1:0]  w_accepted;
    logic [CNT_WIDTH-1:0]  w_wreq_count;
    logic [CNT_WIDTH-1:0]  w_wack_count;
    logic                  w_start_accept;
    logic                  w_cnt_rstn;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_ack_live;
    logic                  w_wack_full;
    logic                  w_wack_inc;
    logic                  w_ovf_set;

    // Starting a command clears all three counters through their reset input.
    assign w_start_accept = (r_state == IDLE) && WRITE_START;
    assign w_cnt_rstn     = RSTN && !w_start_accept;

    assign w_in_ready  = (r_state == WRITE) && (w_accepted < r_length);
    assign w_accept    = IN_VALID && w_in_ready;
    assign w_last_beat = w_accept && (w_accepted == (r_length - CNT_WIDTH'(1)));

    // Acks outside a command are stray and ignored; acks beyond length are flagged.
    assign w_ack_live  = WACK && (r_state != IDLE);
    assign w_wack_full = (w_wack_count == r_length);
    assign w_wack_inc  = w_ack_live && !w_wack_full;
    assign w_ovf_set   = w_ack_live && w_wack_full;

    write_engine_counter #(.WIDTH(CNT_WIDTH)) u_accept_cnt (
        .CLK   (CLK),
        .RSTN  (w_cnt_rstn),
        .EN    (w_accept),
        .VALUE (w_accepted)
    );

    write_engine_counter #(.WIDTH(CNT_WIDTH)) u_wreq_cnt (
        .CLK   (CLK),
        .RSTN  (w_cnt_rstn),
        .EN    (r_wreq),
        .VALUE (w_wreq_count)
    );

    write_engine_counter #(.WIDTH(CNT_WIDTH)) u_wack_cnt (
        .CLK   (CLK),
        .RSTN  (w_cnt_rstn),
        .EN    (w_wack_inc),
        .VALUE (w_wack_count)
    );

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (WRITE_START && (WRITE_LENGTH != CNT_WIDTH'(0))) begin
                    w_state_next = WRITE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WRITE: begin
                if (w_last_beat) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = WRITE;
                end
            end
            DRAIN: begin
                if (w_wack_full) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, command latches, write-request pipeline stage and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state    <= IDLE;
            r_length   <= {CNT_WIDTH{1'b0}};
            r_addr     <= {ADDR_WIDTH{1'b0}};
            r_wreq     <= 1'b0;
            r_waddr    <= {ADDR_WIDTH{1'b0}};
            r_wdata    <= {DATA_WIDTH{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wreq  <= w_accept;
            if (w_start_accept) begin
                r_length <= WRITE_LENGTH;
                r_addr   <= WADDR_START;
            end else if (w_accept) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_accept) begin
                r_waddr <= r_addr;
                r_wdata <= IN_DATA;
            end
            if (w_start_accept) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign BUSY            = (r_state != IDLE);
    assign WREQ_COUNT_DONE = (w_wreq_count == r_length);
    assign WACK_COUNT_DONE = w_wack_full;
    assign WACK_OVERFLOW   = r_overflow;
    assign IN_READY        = w_in_ready;
    assign WREQ            = r_wreq;
    assign WADDR           = r_waddr;
    assign WDATA           = r_wdata;

endmodule

// File: tb/tb_write_engine.sv
// Self-checking bench for write_engine: directed scenarios plus randomized
// commands, compared each cycle against a transaction-level reference model.
module tb_write_engine;

    logic        clk = 1'b0;
    logic        rstn;
    logic        write_start;
    logic [31:0] waddr_start;
    logic [31:0] write_length;
    logic        in_valid;
    logic [63:0] in_data;
    logic        wack;

    logic        o_busy, o_wreq_done, o_wack_done, o_ovf, o_in_ready, o_wreq;
    logic [31:0] o_waddr;
    logic [63:0] o_wdata;
    logic        o8_busy, o8_wreq_done, o8_wack_done, o8_ovf, o8_in_ready, o8_wreq;
    logic [7:0]  o8_waddr;
    logic [63:0] o8_wdata;

    always #5 clk = ~clk;

    write_engine #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .CLK(clk), .RSTN(rstn), .WRITE_START(write_start), .WADDR_START(waddr_start),
        .WRITE_LENGTH(write_length), .BUSY(o_busy), .WREQ_COUNT_DONE(o_wreq_done),
        .WACK_COUNT_DONE(o_wack_done), .WACK_OVERFLOW(o_ovf), .IN_VALID(in_valid),
        .IN_DATA(in_data), .IN_READY(o_in_ready), .WREQ(o_wreq), .WADDR(o_waddr),
        .WDATA(o_wdata), .WACK(wack)
    );

    write_engine #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) dut8 (
        .CLK(clk), .RSTN(rstn), .WRITE_START(write_start), .WADDR_START(waddr_start[7:0]),
        .WRITE_LENGTH(write_length), .BUSY(o8_busy), .WREQ_COUNT_DONE(o8_wreq_done),
        .WACK_COUNT_DONE(o8_wack_done), .WACK_OVERFLOW(o8_ovf), .IN_VALID(in_valid),
        .IN_DATA(in_data), .IN_READY(o8_in_ready), .WREQ(o8_wreq), .WADDR(o8_waddr),
        .WDATA(o8_wdata), .WACK(wack)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_mode = 0;     // 0: random 0..3 cycle delay, 1: fixed 3 cycles, 2: same cycle
    logic inject = 1'b0;  // add one spurious ack once every ack has been received
    int due[$];
    int wreq_seen = 0;

    // Reference model: a command in flight, beats taken, writes issued, acks counted.
    logic        m_active = 1'b0;
    logic [31:0] m_len = 32'd0, m_acc = 32'd0, m_issued = 32'd0, m_acks = 32'd0;
    logic [31:0] m_addr = 32'd0, m_waddr = 32'd0;
    logic [63:0] m_wdata = 64'd0;
    logic        m_wreq = 1'b0, m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic acc_now, exit_now, found;
        wack  = 1'b0;
        found = 1'b0;
        if (o_wreq) begin
            wreq_seen++;
            if (ack_mode == 2) wack = 1'b1;
            else due.push_back(cyc + ((ack_mode == 1) ? 3 : int'($urandom_range(0, 3))));
        end
        if (ack_mode != 2) begin
            for (int i = 0; i < due.size(); i++) begin
                if (!found && due[i] <= cyc) begin
                    due.delete(i);
                    found = 1'b1;
                end
            end
            if (found) wack = 1'b1;
        end
        if (inject && m_active && m_acc == m_len && m_acks == m_len) wack = 1'b1;

        chk("BUSY", {63'd0, o_busy}, {63'd0, m_active});
        chk("IN_READY", {63'd0, o_in_ready}, {63'd0, m_active && (m_acc < m_len)});
        chk("WREQ", {63'd0, o_wreq}, {63'd0, m_wreq});
        chk("WADDR", {32'd0, o_waddr}, {32'd0, m_waddr});
        chk("WDATA", o_wdata, m_wdata);
        chk("WREQ_COUNT_DONE", {63'd0, o_wreq_done}, {63'd0, m_issued == m_len});
        chk("WACK_COUNT_DONE", {63'd0, o_wack_done}, {63'd0, m_acks == m_len});
        chk("WACK_OVERFLOW", {63'd0, o_ovf}, {63'd0, m_ovf});
        chk("WREQ_A8", {63'd0, o8_wreq}, {63'd0, m_wreq});
        chk("WADDR_A8", {56'd0, o8_waddr}, {56'd0, m_waddr[7:0]});

        acc_now  = m_active && (m_acc < m_len) && in_valid;
        exit_now = m_active && (m_acc == m_len) && (m_acks == m_len);
        if (!rstn) begin
            m_active = 1'b0; m_len = 32'd0; m_acc = 32'd0; m_issued = 32'd0;
            m_acks = 32'd0; m_addr = 32'd0; m_waddr = 32'd0; m_wdata = 64'd0;
            m_wreq = 1'b0; m_ovf = 1'b0;
        end else if (!m_active && write_start) begin
            m_len = write_length; m_addr = waddr_start; m_acc = 32'd0;
            m_issued = 32'd0; m_acks = 32'd0; m_ovf = 1'b0;
            m_active = (write_length != 32'd0);
            m_wreq = 1'b0;
        end else begin
            m_issued = m_issued + {31'd0, m_wreq};
            if (m_active && wack) begin
                if (m_acks == m_len) m_ovf = 1'b1;
                else m_acks = m_acks + 32'd1;
            end
            m_wreq = acc_now;
            if (acc_now) begin
                m_waddr = m_addr;
                m_wdata = in_data;
                m_addr  = m_addr + 32'd1;
                m_acc   = m_acc + 32'd1;
            end
            if (exit_now) m_active = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // vprob: percent chance of IN_VALID; pat/plen: explicit IN_VALID bits (LSB first)
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] len, input int vprob,
                           input logic [15:0] pat, input int plen,
                           input int restart_at, input int reset_at);
        int n;
        wreq_seen    = 0;
        write_start  = 1'b1;
        waddr_start  = a;
        write_length = len;
        in_valid     = 1'b0;
        in_data      = {$urandom, $urandom};
        step();
        write_start = 1'b0;
        n = 0;
        while (n < 300 && (m_active || due.size() != 0)) begin
            if (plen > 0) in_valid = (n < plen) ? pat[n] : 1'b0;
            else          in_valid = (int'($urandom_range(0, 99)) < vprob);
            in_data      = {$urandom, $urandom};
            write_start  = (n == restart_at);
            write_length = (n == restart_at) ? 32'd9 : len;
            rstn         = !(n == reset_at);
            step();
            n++;
        end
        write_start = 1'b0;
        rstn        = 1'b1;
        in_valid    = 1'b0;
        repeat (2) step();
        chk("cmd_finished_busy", {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        rstn = 1'b0; write_start = 1'b0; waddr_start = 32'd0; write_length = 32'd0;
        in_valid = 1'b0; in_data = 64'd0; wack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step();
        rstn = 1'b1;
        step();

        ack_mode = 1;
        run_cmd(32'h100, 32'd4, 100, 16'd0, 0, -1, -1);
        chk("burst_wreq_count", wreq_seen, 64'd4);

        ack_mode = 0;
        run_cmd(32'h200, 32'd3, 0, 16'b10_1001, 6, -1, -1);
        chk("gapped_wreq_count", wreq_seen, 64'd3);

        run_cmd(32'h300, 32'd0, 100, 16'd0, 0, -1, -1);
        chk("zero_len_wreq_count", wreq_seen, 64'd0);
        chk("zero_len_wreq_done", {63'd0, o_wreq_done}, 64'd1);
        chk("zero_len_wack_done", {63'd0, o_wack_done}, 64'd1);

        run_cmd(32'h400, 32'd2, 100, 16'd0, 0, 1, -1);
        chk("busy_start_wreq_count", wreq_seen, 64'd2);

        run_cmd(32'hFE, 32'd3, 100, 16'd0, 0, -1, -1);
        chk("wrap_last_addr_a8", {56'd0, o8_waddr}, 64'h00);
        chk("wrap_last_addr_a32", {32'd0, o_waddr}, 64'h100);

        ack_mode = 2;
        inject   = 1'b1;
        run_cmd(32'h500, 32'd2, 100, 16'd0, 0, -1, -1);
        inject = 1'b0;
        chk("overflow_sticky", {63'd0, o_ovf}, 64'd1);

        ack_mode = 1;
        run_cmd(32'h600, 32'd5, 100, 16'd0, 0, -1, 2);
        chk("reset_wreq_count", wreq_seen, 64'd2);
        chk("overflow_cleared", {63'd0, o_ovf}, 64'd0);
        run_cmd(32'h700, 32'd1, 100, 16'd0, 0, -1, -1);
        chk("after_reset_wack_done", {63'd0, o_wack_done}, 64'd1);

        ack_mode = 0;
        repeat (30) begin
            run_cmd($urandom, 32'($urandom_range(1, 12)), int'($urandom_range(30, 100)),
                    16'd0, 0, -1, -1);
        end
        run_cmd(32'hFFFF_FFFF, 32'd3, 100, 16'd0, 0, -1, -1);
        chk("wrap_addr_a32_top", {32'd0, o_waddr}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
